execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
Parametrised execute stage for the SimpleRISC pipeline. It sits between the decode/operand-fetch register and the memory stage. Alongside the existing single-cycle ALU/branch path, it adds an iterative multiply/divide unit with a busy stall, a valid/ready handshake on both sides, flush support and a configurable data width. It produces the E/M pipeline register, the branch redirect and the GT/EQ flags.

Parameters:
XLEN, 32, datapath width; must be at least 8 and a power of two
REGW, 4, register-specifier width
MD_CYCLES, XLEN, iteration count of the multiply/divide unit (1 bit per cycle)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decode stage presents an instruction
in_ready  out  1  execute can accept this cycle
op  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 CMP, 6 AND, 7 OR, 8 NOT, 9 MOV, 10 LSL, 11 LSR, 12 ASR, 15 NOP
a_in, b_in, st_data_in  in  XLEN  operands and store data from the register file or immediate
fwd_a, fwd_b, fwd_st  in  2  0 = own operand, 1 = fwd_m_data, 2 = fwd_wb_data, 3 = own operand
fwd_m_data, fwd_wb_data  in  XLEN  forwarded values
pc_in, branch_target_in  in  XLEN  instruction PC and decoded target
is_beq, is_bgt, is_ubranch, is_ret, is_ld, is_st, is_wb  in  1  decoded controls
rd_in  in  REGW  destination register
flush  in  1  kills the in-flight instruction and the accept path
branch_taken  out  1  redirect request, combinational
branch_pc  out  XLEN  a_fwd when is_ret, else branch_target_in
out_valid  out  1  E/M register holds a live instruction
m_ready  in  1  memory stage consumes E/M
alu_result_m, st_data_m, pc_m  out  XLEN  E/M register contents
rd_m  out  REGW  E/M destination
is_ld_m, is_st_m, is_wb_m  out  1  E/M controls
flag_gt, flag_eq  out  1  architectural flags
div0  out  1  sticky divide-by-zero indication; cleared only by rst

Behaviour:
- Reset: clk, rst sync active-high. All registered outputs are 0: out_valid, E/M fields, flags, div0. FSM goes to IDLE and in_ready=1 after reset.
- Operand select: a_fwd, b_fwd and st_fwd are chosen by the fwd_* selects before any use.
- Accept condition: accept = in_valid & in_ready & !flush.
- in_ready = (state==IDLE) & (!out_valid | m_ready).
- Single-cycle ops: accept at edge N loads E/M at edge N, so out_valid=1 from N+1. Latency is 1.
- Arithmetic: all modulo 2^XLEN.
- Shifts: use b_fwd[log2(XLEN)-1:0]. ASR is sign-extending.
- CMP: result field = 0. On accept, flag_gt = signed(a)>signed(b) and flag_eq = (a==b); the flags are visible from the next cycle.
- Branch: branch_taken = accept & (is_ubranch | (is_beq & flag_eq) | (is_bgt & flag_gt)). It uses the registered flags, so a CMP immediately before a branch is already resolved.
- FSM states IDLE, BUSY, DONE.
  - IDLE -> BUSY on accept of MUL, DIV or MOD. Operands and controls are latched and the counter is loaded with MD_CYCLES.
  - BUSY: one shift-add (MUL, low XLEN bits, unsigned) or one restoring-divide step (unsigned) per cycle. Counter decrements; moves to DONE when counter reaches 1.
  - DONE: loads E/M once the E/M slot is free (!out_valid | m_ready), then returns to IDLE.
  - Total latency from accept to out_valid = MD_CYCLES+2.
- Divide by zero: detected at accept. Skips BUSY and goes straight to DONE. DIV result is all ones, MOD result is the dividend, and div0 is set.
- E/M register hold: while out_valid & !m_ready it holds its contents. When out_valid & m_ready and nothing new is loaded, out_valid goes to 0 at the next edge.
- flush:
  - Synchronous. Next edge: out_valid=0 and FSM to IDLE, aborting any multiply/divide in progress.
  - Flags, div0 and the E/M data fields are unchanged; only out_valid drops.
  - flush has priority over accept and DONE in the same cycle.
- rst has priority over flush.
- op NOP or an undefined op: passes through with result 0 and is_wb forced 0 in E/M.

Test Plan:
- Forwarding (XLEN=32): ADD with a_in=5, fwd_b=1, fwd_m_data=7 -> next cycle out_valid=1, alu_result_m=12, in_ready stays 1.
- MUL: a=0x0001_0003, b=0x0000_0010 -> in_ready=0 for 33 cycles, out_valid at accept+34, alu_result_m=0x0010_0030.
- Signed compare: CMP a=0xFFFF_FFFF, b=1 -> flag_gt=0, flag_eq=0. Following BGT -> branch_taken=0. CMP a=3, b=3 then BEQ with target 0x40 -> branch_taken=1, branch_pc=0x40.
- Divide by zero: DIV a=9, b=0 -> result 0xFFFF_FFFF, div0=1. MOD a=9, b=0 -> result 9.
- Backpressure: m_ready=0 with out_valid=1 and a new in_valid -> in_ready=0, E/M unchanged for 5 cycles. Raise m_ready -> the new instruction loads on the next edge.
- Mid-operation: flush 10 cycles into a DIV -> out_valid stays 0 and in_ready=1 next cycle. rst asserted during BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/execute_stage_mc.sv
// Execute stage for the SimpleRISC pipeline. It contains a single-cycle ALU and
// branch path, plus an iterative unsigned multiply/divide unit that stalls
// in_ready while it runs. The stage drives the E/M register with a valid/ready
// handshake, the branch redirect, and the GT/EQ flags.
module execute_stage_mc #(
    parameter int XLEN      = 32,
    parameter int REGW      = 4,
    parameter int MD_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [XLEN-1:0] st_data_in,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [1:0]      fwd_st,
    input  logic [XLEN-1:0] fwd_m_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] branch_target_in,
    input  logic            is_beq,
    input  logic            is_bgt,
    input  logic            is_ubranch,
    input  logic            is_ret,
    input  logic            is_ld,
    input  logic            is_st,
    input  logic            is_wb,
    input  logic [REGW-1:0] rd_in,
    input  logic            flush,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_pc,
    output logic            out_valid,
    input  logic            m_ready,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] st_data_m,
    output logic [XLEN-1:0] pc_m,
    output logic [REGW-1:0] rd_m,
    output logic            is_ld_m,
    output logic            is_st_m,
    output logic            is_wb_m,
    output logic            flag_gt,
    output logic            flag_eq,
    output logic            div0
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(MD_CYCLES + 1);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4,  OP_CMP = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8,  OP_MOV = 4'd9,  OP_LSL = 4'd10, OP_LSR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t state_reg, state_next;

    logic [XLEN-1:0] a_fwd, b_fwd, st_fwd;
    logic            em_free, accept, is_md, md_div0, load_single, load_md;
    logic [XLEN-1:0] alu_res, md_res;
    logic            alu_wb;
    logic [SHW-1:0]  shamt;

    // Multiply/divide working registers: md_a is multiplicand or quotient,
    // md_b is multiplier or divisor, md_acc is product or remainder.
    logic [XLEN-1:0] md_a_reg, md_b_reg, md_acc_reg;
    logic [CW-1:0]   cnt_reg;
    logic [3:0]      md_op_reg;
    logic [XLEN-1:0] md_pc_reg, md_st_reg;
    logic [REGW-1:0] md_rd_reg;
    logic            md_ld_reg, md_sst_reg, md_wb_reg;
    logic [XLEN:0]   div_trial, div_diff;

    logic            out_valid_reg, is_ld_reg, is_st_reg, is_wb_reg;
    logic [XLEN-1:0] result_reg, st_data_reg, pc_reg;
    logic [REGW-1:0] rd_reg;
    logic            flag_gt_reg, flag_eq_reg, div0_reg;

    function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] own,
                                             input logic [XLEN-1:0] m, input logic [XLEN-1:0] wb);
        case (sel)
            2'd1:    pick = m;
            2'd2:    pick = wb;
            default: pick = own;
        endcase
    endfunction

    assign a_fwd  = pick(fwd_a,  a_in,       fwd_m_data, fwd_wb_data);
    assign b_fwd  = pick(fwd_b,  b_in,       fwd_m_data, fwd_wb_data);
    assign st_fwd = pick(fwd_st, st_data_in, fwd_m_data, fwd_wb_data);
    assign shamt  = b_fwd[SHW-1:0];

    assign em_free     = !out_valid_reg || m_ready;
    assign in_ready    = (state_reg == IDLE) && em_free;
    assign accept      = in_valid && in_ready && !flush;
    assign is_md       = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    assign md_div0     = (op != OP_MUL) && (b_fwd == '0);
    assign load_single = accept && !is_md;
    assign load_md     = (state_reg == DONE) && em_free && !flush;

    // Branches resolve against the registered flags, so a preceding CMP is already visible.
    assign branch_taken = accept && (is_ubranch || (is_beq && flag_eq_reg) || (is_bgt && flag_gt_reg));
    assign branch_pc    = is_ret ? a_fwd : branch_target_in;

    // Single-cycle ALU; NOP and undefined opcodes produce 0 and suppress writeback.
    always_comb begin
        alu_res = '0;
        alu_wb  = is_wb;
        case (op)
            OP_ADD:                        alu_res = a_fwd + b_fwd;
            OP_SUB:                        alu_res = a_fwd - b_fwd;
            OP_AND:                        alu_res = a_fwd & b_fwd;
            OP_OR:                         alu_res = a_fwd | b_fwd;
            OP_NOT:                        alu_res = ~a_fwd;
            OP_MOV:                        alu_res = b_fwd;
            OP_LSL:                        alu_res = a_fwd << shamt;
            OP_LSR:                        alu_res = a_fwd >> shamt;
            OP_ASR:                        alu_res = $unsigned($signed(a_fwd) >>> shamt);
            OP_CMP, OP_MUL, OP_DIV, OP_MOD: alu_res = '0;
            default:                       alu_wb  = 1'b0;
        endcase
    end

    // One restoring-divide step: shift the next dividend bit into the remainder and try to subtract.
    assign div_trial = {md_acc_reg, md_a_reg[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, md_b_reg};
    assign md_res    = (md_op_reg == OP_DIV) ? md_a_reg : md_acc_reg;

    // Next-state logic; flush aborts any multiply/divide and wins over DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && is_md) state_next = md_div0 ? DONE : BUSY;
            BUSY:    if (cnt_reg == CW'(1)) state_next = DONE;
            DONE:    if (em_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Multiply/divide datapath: latch on accept, then one bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_a_reg <= '0; md_b_reg <= '0; md_acc_reg <= '0; cnt_reg <= '0;
            md_op_reg <= '0; md_pc_reg <= '0; md_st_reg <= '0; md_rd_reg <= '0;
            md_ld_reg <= 1'b0; md_sst_reg <= 1'b0; md_wb_reg <= 1'b0;
        end else if (accept && is_md) begin
            md_op_reg  <= op;
            md_pc_reg  <= pc_in;
            md_st_reg  <= st_fwd;
            md_rd_reg  <= rd_in;
            md_ld_reg  <= is_ld;
            md_sst_reg <= is_st;
            md_wb_reg  <= is_wb;
            cnt_reg    <= CW'(MD_CYCLES);
            md_b_reg   <= b_fwd;
            if (md_div0) begin
                md_a_reg   <= '1;
                md_acc_reg <= a_fwd;
            end else begin
                md_a_reg   <= a_fwd;
                md_acc_reg <= '0;
            end
        end else if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg - CW'(1);
            if (md_op_reg == OP_MUL) begin
                if (md_b_reg[0]) md_acc_reg <= md_acc_reg + md_a_reg;
                md_a_reg <= md_a_reg << 1;
                md_b_reg <= md_b_reg >> 1;
            end else if (!div_diff[XLEN]) begin
                md_acc_reg <= div_diff[XLEN-1:0];
                md_a_reg   <= {md_a_reg[XLEN-2:0], 1'b1};
            end else begin
                md_acc_reg <= div_trial[XLEN-1:0];
                md_a_reg   <= {md_a_reg[XLEN-2:0], 1'b0};
            end
        end
    end

    // E/M register: flush only drops valid; otherwise load, hold under backpressure, or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0; result_reg <= '0; st_data_reg <= '0; pc_reg <= '0;
            rd_reg <= '0; is_ld_reg <= 1'b0; is_st_reg <= 1'b0; is_wb_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load_single) begin
            out_valid_reg <= 1'b1;
            result_reg    <= alu_res;
            st_data_reg   <= st_fwd;
            pc_reg        <= pc_in;
            rd_reg        <= rd_in;
            is_ld_reg     <= is_ld;
            is_st_reg     <= is_st;
            is_wb_reg     <= alu_wb;
        end else if (load_md) begin
            out_valid_reg <= 1'b1;
            result_reg    <= md_res;
            st_data_reg   <= md_st_reg;
            pc_reg        <= md_pc_reg;
            rd_reg        <= md_rd_reg;
            is_ld_reg     <= md_ld_reg;
            is_st_reg     <= md_sst_reg;
            is_wb_reg     <= md_wb_reg;
        end else if (m_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Architectural flags from CMP, and the sticky divide-by-zero indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_gt_reg <= 1'b0;
            flag_eq_reg <= 1'b0;
            div0_reg    <= 1'b0;
        end else begin
            if (accept && op == OP_CMP) begin
                flag_gt_reg <= $signed(a_fwd) > $signed(b_fwd);
                flag_eq_reg <= a_fwd == b_fwd;
            end
            if (accept && is_md && md_div0) div0_reg <= 1'b1;
        end
    end

    assign out_valid    = out_valid_reg;
    assign alu_result_m = result_reg;
    assign st_data_m    = st_data_reg;
    assign pc_m         = pc_reg;
    assign rd_m         = rd_reg;
    assign is_ld_m      = is_ld_reg;
    assign is_st_m      = is_st_reg;
    assign is_wb_m      = is_wb_reg;
    assign flag_gt      = flag_gt_reg;
    assign flag_eq      = flag_eq_reg;
    assign div0         = div0_reg;
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed and randomized checks of execute_stage_mc against an arithmetic reference model.
module tb_execute_stage_mc;
    localparam int XLEN = 32;
    localparam int REGW = 4;
    localparam int MDC  = 32;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, m_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a_in, b_in, st_data_in, fwd_m_data, fwd_wb_data, pc_in, branch_target_in;
    logic [1:0]      fwd_a, fwd_b, fwd_st;
    logic            is_beq, is_bgt, is_ubranch, is_ret, is_ld, is_st, is_wb;
    logic [REGW-1:0] rd_in, rd_m;
    logic            branch_taken, out_valid, is_ld_m, is_st_m, is_wb_m, flag_gt, flag_eq, div0;
    logic [XLEN-1:0] branch_pc, alu_result_m, st_data_m, pc_m;

    int checks = 0;
    int errors = 0;
    logic gt_m = 1'b0, eq_m = 1'b0, div0_m = 1'b0;
    logic [31:0] last_res = '0;
    logic last_bt;
    logic [31:0] last_bpc;

    always #5 clk = ~clk;

    execute_stage_mc #(.XLEN(XLEN), .REGW(REGW), .MD_CYCLES(MDC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_in(a_in), .b_in(b_in), .st_data_in(st_data_in),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st),
        .fwd_m_data(fwd_m_data), .fwd_wb_data(fwd_wb_data),
        .pc_in(pc_in), .branch_target_in(branch_target_in),
        .is_beq(is_beq), .is_bgt(is_bgt), .is_ubranch(is_ubranch), .is_ret(is_ret),
        .is_ld(is_ld), .is_st(is_st), .is_wb(is_wb), .rd_in(rd_in), .flush(flush),
        .branch_taken(branch_taken), .branch_pc(branch_pc), .out_valid(out_valid),
        .m_ready(m_ready), .alu_result_m(alu_result_m), .st_data_m(st_data_m), .pc_m(pc_m),
        .rd_m(rd_m), .is_ld_m(is_ld_m), .is_st_m(is_st_m), .is_wb_m(is_wb_m),
        .flag_gt(flag_gt), .flag_eq(flag_eq), .div0(div0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the instruction definitions.
    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd4:    return (b == 0) ? a : a % b;
            4'd6:    return a & b;
            4'd7:    return a | b;
            4'd8:    return ~a;
            4'd9:    return b;
            4'd10:   return a << b[4:0];
            4'd11:   return a >> b[4:0];
            4'd12:   return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_ctl();
        in_valid = 0; is_beq = 0; is_bgt = 0; is_ubranch = 0; is_ret = 0;
        is_ld = 0; is_st = 0; is_wb = 0;
    endtask

    // Issue one instruction with effective operands a/b and check the E/M result.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] st, pc, exp_st, exp_r;
        logic [3:0]  rdv;
        logic        wbv, ldv, stv, ir, md, exp_wb;
        int          lat, busy, exp_lat;
        st = $urandom; pc = $urandom; rdv = 4'($urandom);
        wbv = 1'($urandom); ldv = 1'($urandom); stv = 1'($urandom);
        op = o;
        a_in = (fwd_a == 2'd1 || fwd_a == 2'd2) ? ~a : a;
        b_in = (fwd_b == 2'd1 || fwd_b == 2'd2) ? ~b : b;
        st_data_in = st;
        exp_st = (fwd_st == 2'd1) ? fwd_m_data : (fwd_st == 2'd2) ? fwd_wb_data : st;
        pc_in = pc; rd_in = rdv; is_wb = wbv; is_ld = ldv; is_st = stv; in_valid = 1;
        #1;
        ir = in_ready; last_bt = branch_taken; last_bpc = branch_pc;
        chk({tag, "_rdy"}, 32'(ir), 32'd1);
        @(posedge clk);
        @(negedge clk);
        clear_ctl();
        lat = 1; busy = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        md = (o == 4'd2) || (o == 4'd3) || (o == 4'd4);
        exp_r = ref_res(o, a, b);
        exp_lat = !md ? 1 : ((o != 4'd2 && b == 0) ? 2 : MDC + 2);
        exp_wb = wbv && (o <= 4'd12);
        if (o == 4'd5) begin gt_m = $signed(a) > $signed(b); eq_m = (a == b); end
        if ((o == 4'd3 || o == 4'd4) && b == 0) div0_m = 1'b1;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, alu_result_m, exp_r);
        chk({tag, "_wb"}, 32'(is_wb_m), 32'(exp_wb));
        chk({tag, "_ctl"}, {28'd0, is_ld_m, is_st_m, 2'd0}, {28'd0, ldv, stv, 2'd0});
        chk({tag, "_rd"}, 32'(rd_m), 32'(rdv));
        chk({tag, "_pc"}, pc_m, pc);
        chk({tag, "_st"}, st_data_m, exp_st);
        chk({tag, "_flags"}, {29'd0, flag_gt, flag_eq, div0}, {29'd0, gt_m, eq_m, div0_m});
        if (md && exp_lat > 2) chk({tag, "_busy"}, 32'(busy), 32'(MDC + 1));
        last_res = exp_r;
        $display("txn %s op=%0d a=%08h b=%08h res=%08h lat=%0d", tag, o, a, b, alu_result_m, lat);
    endtask

    initial begin
        int cnt;
        logic [3:0] o;
        rst = 1; flush = 0; m_ready = 1; clear_ctl();
        op = 4'd15; a_in = 0; b_in = 0; st_data_in = 0; fwd_a = 0; fwd_b = 0; fwd_st = 0;
        fwd_m_data = 0; fwd_wb_data = 0; pc_in = 0; branch_target_in = 0; rd_in = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", {27'd0, out_valid, flag_gt, flag_eq, div0, in_ready},
            {27'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("rst_res", alu_result_m, 32'd0);
        rst = 0;
        @(negedge clk);

        // Forwarding paths.
        fwd_b = 2'd1; fwd_m_data = 32'd7;
        do_op(4'd0, 32'd5, 32'd7, "fwd_add");
        chk("fwd_add_ready_after", 32'(in_ready), 32'd1);
        fwd_a = 2'd2; fwd_b = 2'd3; fwd_st = 2'd1; fwd_wb_data = 32'h100; fwd_m_data = 32'hCAFE;
        do_op(4'd1, 32'h100, 32'h20, "fwd_sub");
        fwd_a = 0; fwd_b = 0; fwd_st = 0;

        // Random single-cycle ops, including NOP and undefined opcodes.
        for (int i = 0; i < 24; i++) begin
            o = 4'($urandom_range(0, 15));
            if (o == 4'd2 || o == 4'd3 || o == 4'd4) o = 4'd9;
            do_op(o, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom, "rand_alu");
        end

        // Random multiply/divide, small and large divisors.
        for (int i = 0; i < 6; i++)
            do_op(4'(2 + i % 3), $urandom, (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom, "rand_md");
        do_op(4'd2, 32'h0001_0003, 32'h0000_0010, "mul_dir");
        chk("mul_dir_val", alu_result_m, 32'h0010_0030);

        // Signed compare then branches on the registered flags.
        do_op(4'd5, 32'hFFFF_FFFF, 32'd1, "cmp_neg");
        is_bgt = 1; branch_target_in = 32'h80;
        do_op(4'd15, 32'd0, 32'd0, "bgt");
        chk("bgt_taken", 32'(last_bt), 32'(gt_m));
        do_op(4'd5, 32'd3, 32'd3, "cmp_eq");
        is_beq = 1; branch_target_in = 32'h40;
        do_op(4'd15, 32'd0, 32'd0, "beq");
        chk("beq_taken", 32'(last_bt), 32'(eq_m));
        chk("beq_pc", last_bpc, 32'h40);
        is_ret = 1; is_ubranch = 1;
        do_op(4'd15, 32'h1234, 32'd0, "ret");
        chk("ret_taken", 32'(last_bt), 32'd1);
        chk("ret_pc", last_bpc, 32'h1234);

        // Divide by zero.
        do_op(4'd3, 32'd9, 32'd0, "div0");
        do_op(4'd4, 32'd9, 32'd0, "mod0");

        // Backpressure: E/M holds and the next instruction waits.
        @(negedge clk);
        m_ready = 0;
        do_op(4'd0, 32'd1, 32'd2, "bp_first");
        op = 4'd1; a_in = 32'd10; b_in = 32'd3; in_valid = 1; is_wb = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_stall_rdy", 32'(in_ready), 32'd0);
            @(negedge clk);
            chk("bp_hold", {alu_result_m[30:0], out_valid}, {31'd3, 1'b1});
        end
        m_ready = 1;
        #1 chk("bp_release_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        clear_ctl();
        chk("bp_load", {alu_result_m[30:0], out_valid}, {31'd7, 1'b1});
        last_res = 32'd7;
        @(negedge clk);
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Flush 10 cycles into a divide.
        op = 4'd3; a_in = 32'd1000; b_in = 32'd7; in_valid = 1;
        @(negedge clk);
        clear_ctl();
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_state", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("flush_no_result", 32'(cnt), 32'd0);
        chk("flush_em_kept", alu_result_m, last_res);
        chk("flush_flags", {29'd0, flag_gt, flag_eq, div0}, {29'd0, gt_m, eq_m, div0_m});

        // Flush wins over a same-cycle accept.
        op = 4'd0; a_in = 32'd1; b_in = 32'd1; in_valid = 1; is_ubranch = 1; flush = 1;
        #1 chk("flush_no_branch", 32'(branch_taken), 32'd0);
        @(negedge clk);
        clear_ctl(); flush = 0;
        chk("flush_no_accept", {alu_result_m[30:0], out_valid}, {last_res[30:0], 1'b0});

        // Reset in the middle of a multiply.
        op = 4'd2; a_in = $urandom; b_in = $urandom; in_valid = 1;
        @(negedge clk);
        clear_ctl();
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_busy_state", {27'd0, out_valid, flag_gt, flag_eq, div0, in_ready},
            {27'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("rst_busy_res", alu_result_m, 32'd0);
        chk("rst_busy_rd", 32'(rd_m), 32'd0);
        gt_m = 0; eq_m = 0; div0_m = 0;
        do_op(4'd0, $urandom, $urandom, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
